// File: rtl/uart_pkg.sv
// Shared constants for the serial monitor UART: state encodings, oversampling and vote phases.
// Helper functions for 3-sample majority vote and even-parity checking.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [3:0] VOTE_PH_A = 4'd7;
    localparam logic [3:0] VOTE_PH_B = 4'd8;
    localparam logic [3:0] VOTE_PH_C = 4'd9;

    localparam logic [7:0] ASCII_CR = 8'd13;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE      = 3'd0;
    localparam rx_state_t ST_START     = 3'd1;
    localparam rx_state_t ST_DATA      = 3'd2;
    localparam rx_state_t ST_PARITY    = 3'd3;
    localparam rx_state_t ST_STOP      = 3'd4;
    localparam rx_state_t ST_WAIT_IDLE = 3'd5;

    function automatic logic vote3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Returns 1 when data plus parity bit hold an odd number of ones.
    function automatic logic even_par_err(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-clock pulse every DIV clocks.
// Shared between the monitor's receiver and transmitter.
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;
    logic          tick_d;

    // Next count and next tick; tick_q is high while cnt_q sits at LAST.
    always_comb begin
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        tick_d = (cnt_d == LAST);
    end

    // Counter and tick flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx_frontend.sv
// Oversampling 8N1 UART receiver with majority voting and a valid/ready holding register.
// Define UART_RX_PARITY_EN for an 11-bit frame with even parity checking.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ = 50000000,
    parameter int BAUD     = 300,
    parameter int DIV      = CLOCK_HZ / (BAUD * OVERSAMPLE)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       UART_RX,
    input  logic       rx_ready,
    input  logic       overrun_clear,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       framing_error,
    output logic       parity_error,
    output logic       overrun,
    output logic       busy
);

    logic       tick;
    logic       rx_meta_q;
    logic       rxs_q;

    rx_state_t  state_q, state_d;
    logic [3:0] phase_q, phase_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       samp_a_q, samp_a_d;
    logic       samp_b_q, samp_b_d;
`ifdef UART_RX_PARITY_EN
    logic       par_err_q, par_err_d;
`endif

    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       framing_error_q, framing_error_d;
    logic       parity_error_q, parity_error_d;
    logic       overrun_q, overrun_d;
    logic       busy_q, busy_d;

    logic       vote_s;
    logic       deliver_s;
    logic       frame_err_s;
    logic       accept_s;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    assign vote_s = vote3(samp_a_q, samp_b_q, rxs_q);

    // Frame recovery: bit timing, voting samples and the receive state machine.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        samp_a_d    = samp_a_q;
        samp_b_d    = samp_b_q;
        deliver_s   = 1'b0;
        frame_err_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d   = par_err_q;
`endif
        if (tick) begin
            phase_d = phase_q + 4'd1;
            if (phase_q == VOTE_PH_A) begin
                samp_a_d = rxs_q;
            end else begin
                samp_a_d = samp_a_q;
            end
            if (phase_q == VOTE_PH_B) begin
                samp_b_d = rxs_q;
            end else begin
                samp_b_d = samp_b_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!rxs_q) begin
                        state_d = ST_START;
                        phase_d = 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (phase_q == VOTE_PH_C) begin
                        if (vote_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d   = ST_DATA;
                            bit_cnt_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                            par_err_d = 1'b0;
`endif
                        end
                    end else begin
                        state_d = ST_START;
                    end
                end
                ST_DATA: begin
                    if (phase_q == VOTE_PH_C) begin
                        shift_d[bit_cnt_q] = vote_s;
                        bit_cnt_d          = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (phase_q == VOTE_PH_C) begin
                        par_err_d = even_par_err(shift_q, vote_s);
                        state_d   = ST_STOP;
                    end else begin
                        state_d = ST_PARITY;
                    end
                end
`endif
                ST_STOP: begin
                    if (phase_q == VOTE_PH_C) begin
                        if (vote_s) begin
                            deliver_s = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            frame_err_s = 1'b1;
                            state_d     = ST_WAIT_IDLE;
                        end
                    end else begin
                        state_d = ST_STOP;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rxs_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Holding register, error pulses and sticky overrun.
    always_comb begin
        accept_s   = deliver_s && (!rx_valid_q || rx_ready);
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        if (accept_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
        end else if (rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
        if (deliver_s && !accept_s) begin
            overrun_d = 1'b1;
        end else if (overrun_clear) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
        framing_error_d = frame_err_s;
`ifdef UART_RX_PARITY_EN
        parity_error_d  = accept_s && par_err_q;
`else
        parity_error_d  = 1'b0;
`endif
        busy_d = (state_d != ST_IDLE);
    end

    // Pin synchroniser, idling high out of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= UART_RX;
            rxs_q     <= rx_meta_q;
        end
    end

    // Receive state machine and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            phase_q         <= 4'd0;
            bit_cnt_q       <= 3'd0;
            shift_q         <= 8'd0;
            samp_a_q        <= 1'b1;
            samp_b_q        <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_err_q       <= 1'b0;
`endif
            rx_data_q       <= 8'd0;
            rx_valid_q      <= 1'b0;
            framing_error_q <= 1'b0;
            parity_error_q  <= 1'b0;
            overrun_q       <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            samp_a_q        <= samp_a_d;
            samp_b_q        <= samp_b_d;
`ifdef UART_RX_PARITY_EN
            par_err_q       <= par_err_d;
`endif
            rx_data_q       <= rx_data_d;
            rx_valid_q      <= rx_valid_d;
            framing_error_q <= framing_error_d;
            parity_error_q  <= parity_error_d;
            overrun_q       <= overrun_d;
            busy_q          <= busy_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign framing_error = framing_error_q;
    assign parity_error  = parity_error_q;
    assign overrun       = overrun_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at DIV=10 (160 clocks per bit).
// Parity scenario is included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_frontend;

    localparam int BIT_CLKS = 160;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       UART_RX = 1'b1;
    logic       rx_ready = 1'b0;
    logic       overrun_clear = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_error;
    logic       parity_error;
    logic       overrun;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;
    int fe_cnt  = 0;
    int pe_cnt  = 0;
    int rv_rise = 0;
    logic rv_prev = 1'b0;
    int fe0, pe0, rv0;

    uart_rx_frontend #(
        .CLOCK_HZ(16000),
        .BAUD    (100)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .UART_RX      (UART_RX),
        .rx_ready     (rx_ready),
        .overrun_clear(overrun_clear),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .framing_error(framing_error),
        .parity_error (parity_error),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    // Pulse-high clock counts and valid rising edges, sampled on the falling edge.
    always @(negedge clock) begin
        rv_prev <= rx_valid;
        if (framing_error) fe_cnt <= fe_cnt + 1;
        if (parity_error)  pe_cnt <= pe_cnt + 1;
        if (rx_valid && !rv_prev) rv_rise <= rv_rise + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive_bit(input logic v);
        UART_RX = v;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val, input logic flip_par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ flip_par);
`else
        if (flip_par) UART_RX = 1'b1;
`endif
        drive_bit(stop_val);
        UART_RX = 1'b1;
    endtask

    task automatic pulse_ready();
        rx_ready = 1'b1;
        @(posedge clock);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic snap();
        fe0 = fe_cnt;
        pe0 = pe_cnt;
        rv0 = rv_rise;
    endtask

    initial begin
        wait_clks(3);
        reset = 1'b0;
        wait_clks(2);
        chk("rst_data",    {24'd0, rx_data},       32'h00);
        chk("rst_valid",   {31'd0, rx_valid},      32'd0);
        chk("rst_fe",      {31'd0, framing_error}, 32'd0);
        chk("rst_pe",      {31'd0, parity_error},  32'd0);
        chk("rst_overrun", {31'd0, overrun},       32'd0);
        chk("rst_busy",    {31'd0, busy},          32'd0);
        wait_clks(20);

        // 0x47 with no consumer
        snap();
        send_frame(8'h47, 1'b1, 1'b0);
        wait_clks(5);
        chk("g_valid",   {31'd0, rx_valid}, 32'd1);
        chk("g_data",    {24'd0, rx_data},  32'h47);
        chk("g_fe",      fe_cnt - fe0,      32'd0);
        chk("g_pe",      pe_cnt - pe0,      32'd0);
        chk("g_overrun", {31'd0, overrun},  32'd0);
        chk("g_busy",    {31'd0, busy},     32'd0);
        pulse_ready();
        chk("g_ready_clr", {31'd0, rx_valid}, 32'd0);
        wait_clks(20);

        // 40-clock low glitch
        snap();
        UART_RX = 1'b0;
        wait_clks(30);
        chk("gl_busy_hi", {31'd0, busy}, 32'd1);
        wait_clks(10);
        UART_RX = 1'b1;
        wait_clks(200);
        chk("gl_busy_lo", {31'd0, busy},     32'd0);
        chk("gl_valid",   {31'd0, rx_valid}, 32'd0);
        chk("gl_fe",      fe_cnt - fe0,      32'd0);
        chk("gl_rv",      rv_rise - rv0,     32'd0);

        // 0x0D with stop low, then 240 more low clocks (400 low in total)
        snap();
        send_frame(8'h0D, 1'b0, 1'b0);
        UART_RX = 1'b0;
        wait_clks(240);
        chk("fr_fe_once",  fe_cnt - fe0,      32'd1);
        chk("fr_valid",    {31'd0, rx_valid}, 32'd0);
        chk("fr_wait_busy",{31'd0, busy},     32'd1);
        UART_RX = 1'b1;
        wait_clks(30);
        chk("fr_idle",     {31'd0, busy},     32'd0);
        chk("fr_rv",       rv_rise - rv0,     32'd0);
        wait_clks(20);

        // Back-to-back 0x41, 0x42 without a consumer
        snap();
        send_frame(8'h41, 1'b1, 1'b0);
        send_frame(8'h42, 1'b1, 1'b0);
        wait_clks(5);
        chk("ov_data",    {24'd0, rx_data},  32'h41);
        chk("ov_valid",   {31'd0, rx_valid}, 32'd1);
        chk("ov_set",     {31'd0, overrun},  32'd1);
        chk("ov_pe",      pe_cnt - pe0,      32'd0);
        overrun_clear = 1'b1;
        @(posedge clock);
        #1;
        overrun_clear = 1'b0;
        chk("ov_clear",   {31'd0, overrun},  32'd0);
        chk("ov_keep",    {31'd0, rx_valid}, 32'd1);
        pulse_ready();
        chk("ov_drain",   {31'd0, rx_valid}, 32'd0);
        wait_clks(20);

`ifdef UART_RX_PARITY_EN
        // 0x03 carries a wrong (odd) parity bit
        snap();
        send_frame(8'h03, 1'b1, 1'b1);
        wait_clks(5);
        chk("par_data",  {24'd0, rx_data},  32'h03);
        chk("par_valid", {31'd0, rx_valid}, 32'd1);
        chk("par_pulse", pe_cnt - pe0,      32'd1);
        pulse_ready();
        wait_clks(20);
`endif
        chk("pe_total_before_rst", pe_cnt,
`ifdef UART_RX_PARITY_EN
            32'd1
`else
            32'd0
`endif
        );

        // Reset in the middle of data bit 4 of 0x55
        snap();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
        UART_RX = 1'b1;
        wait_clks(80);
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(1);
        chk("mid_busy",  {31'd0, busy},     32'd0);
        chk("mid_valid", {31'd0, rx_valid}, 32'd0);
        wait_clks(320);
        chk("mid_quiet", rv_rise - rv0,     32'd0);
        chk("mid_fe",    fe_cnt - fe0,      32'd0);
        send_frame(8'h30, 1'b1, 1'b0);
        wait_clks(5);
        chk("mid_data",  {24'd0, rx_data},  32'h30);
        chk("mid_valid2",{31'd0, rx_valid}, 32'd1);
        chk("mid_once",  rv_rise - rv0,     32'd1);
        chk("mid_pe",    pe_cnt - pe0,      32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Oversampling UART receiver placed directly upstream of the serial monitor's command line buffer. Synchronises the raw `UART_RX` pin and recovers 8N1 frames with 3-sample majority voting. Presents each byte on a valid/ready holding register, so the monitor consumes whole bytes instead of sampling the pin itself. Reports framing, overrun and (optionally) parity errors.

## Interface
- `CLOCK_HZ`, 50000000, system clock frequency.
- `BAUD`, 300, line rate.
- `DIV`, `CLOCK_HZ/(BAUD*16)` truncated (10416 by default), clocks per oversample tick; must be ≥ 2.
- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `UART_RX`  in  1  raw serial line; idle high.
- `rx_ready`  in  1  consumer accepts `rx_data` on any edge where `rx_valid`=1.
- `overrun_clear`  in  1  clears sticky `overrun`.
- `rx_data`  out  8  received byte, LSB received first.
- `rx_valid`  out  1  holding register full.
- `framing_error`  out  1  one-clock pulse: stop bit sampled low.
- `parity_error`  out  1  one-clock pulse: parity mismatch (see Configuration).
- `overrun`  out  1  sticky: a frame completed while the holding register was full.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Two-flop synchroniser on `UART_RX`; both flops reset to 1. All logic uses the synchronised value `rxs`.
- Tick counter runs 0..DIV-1 and pulses `tick` at DIV-1. It runs free and is never re-aligned.
- 4-bit `phase` counter advances on each tick within a bit; majority vote of `rxs` at phases 7, 8, 9 gives the bit value, committed at phase 9.
- State machine:
  - IDLE: on a tick with `rxs`=0, go to START with `phase`=1.
  - START: at phase 9, vote=1 → IDLE (glitch, no flag); vote=0 → DATA, `bit_cnt`=0.
  - DATA: shift the vote into bit `bit_cnt`. After bit 7, go to PARITY (macro) or STOP.
  - PARITY: even parity over the data and parity bit; mismatch latches an internal error flag. Go to STOP.
  - STOP: vote=1 → deliver the byte, IDLE. Vote=0 → pulse `framing_error`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until a tick sees `rxs`=1, then IDLE. This handles a break condition.
  - `phase` wraps 15→0 between bits.
- Delivery:
  - If `rx_valid`=0, or `rx_ready`=1 on the same edge: load `rx_data`, set `rx_valid`=1, pulse `parity_error` if the internal flag is set.
  - Otherwise: keep the old byte, set `overrun`=1, drop the new byte (and its parity status).
- `rx_valid` clears on an edge with `rx_ready`=1 and no simultaneous delivery.
- `overrun` clears on `overrun_clear`=1. A simultaneous set has priority.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `framing_error`=0, `parity_error`=0, `overrun`=0, `busy`=0; state IDLE; counters 0.
- Reset asserted mid-frame: immediate return to IDLE; the partial byte is lost and no flags are raised.
- Pin-to-detect latency: 2 clocks for the synchroniser plus up to DIV clocks of tick alignment.
- Delivery: `rx_valid` rises 1 clock after the tick at which the stop bit reaches phase 9.
- Error pulses are exactly one clock wide, on the same edge as the delivery or discard.
- Back-to-back frames: the next start bit is accepted on the first tick after returning to IDLE, with no extra idle bit required.

## Configuration
- `UART_RX_PARITY_EN` defined: 11-bit frame (start, 8 data, even parity, stop); PARITY state present; `parity_error` driven.
- `UART_RX_PARITY_EN` undefined: 10-bit 8N1 frame; PARITY state and logic absent; `parity_error` tied 0.

## Structure
- `uart_pkg`: state enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE), `OVERSAMPLE`=16, vote phases 7/8/9, ASCII CR=13.
- Sub-module `uart_baud_tick`: parameter `DIV`; ports `clock`, `reset`, `tick`. The monitor's transmitter reuses it.

## Test plan
Bench parameters: `CLOCK_HZ`=16000, `BAUD`=100, so DIV=10 and 160 clocks per bit.
- Send 0x47 ('G') 8N1 with `rx_ready`=0 → `rx_valid`=1, `rx_data`=0x47, no error flags; pulse `rx_ready` → `rx_valid`=0 on the next edge.
- Low glitch of 40 clocks on an idle line → remains IDLE, `busy` drops, no valid and no flags.
- Frame 0x0D with stop bit forced low, line held low for 400 clocks → one `framing_error` pulse, `rx_valid`=0, leaves WAIT_IDLE only after the line goes high.
- Send 0x41 then 0x42 without asserting `rx_ready` → `rx_data`=0x41, `overrun`=1; `overrun_clear` → `overrun`=0.
- With the macro defined, send 0x03 with parity bit 1 → `rx_data`=0x03, one `parity_error` pulse.
- Assert `reset` at data bit 4, release, then send 0x30 → only 0x30 is delivered.
